// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiply datapath adapters.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } out_state_t;

    localparam int CONV_W = 64;

    function automatic int idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Clamp a sign-extended value into the signed range of w bits.
    function automatic logic [CONV_W-1:0] sat_conv(
        input logic signed [CONV_W-1:0] v,
        input int                       w
    );
        logic signed [CONV_W-1:0] hi;
        logic signed [CONV_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return $unsigned(hi);
        if (v < lo) return $unsigned(lo);
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/axi_output_adapter.sv
// Captures an NxN result matrix and streams it row-major over AXI-Stream.
// Define AXI_OUT_SAT_EN to saturate elements to OUT_W instead of truncating.
module axi_output_adapter
    import mm_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              results_valid,
    input  logic [N-1:0][N-1:0][ACC_W-1:0]    results,
    output logic                              m_axis_tvalid,
    output logic [OUT_W-1:0]                  m_axis_tdata,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun
);

    localparam int NN    = N * N;
    localparam int IDX_W = idx_w(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NN - 1);

    out_state_t       r_state;
    out_state_t       w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_capture;
    logic             r_overrun;
    logic [ACC_W-1:0] r_buf [NN];
    logic [ACC_W-1:0] w_elem;

    always_comb begin
        w_next        = r_state;
        w_idx_next    = r_idx;
        w_capture     = 1'b0;
        m_axis_tvalid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (results_valid && enable) begin
                    w_capture  = 1'b1;
                    w_idx_next = '0;
                    w_next     = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                busy          = 1'b1;
                if (m_axis_tready) begin
                    if (r_idx == LAST) begin
                        w_idx_next = '0;
                        w_next     = DONE;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_idx_next;
            r_overrun <= r_overrun | (results_valid && (r_state != IDLE));
        end
    end

    // Buffer is written only on capture, so array restarts never disturb a stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) r_buf[i] <= '0;
        end else if (w_capture) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    r_buf[r*N+c] <= results[r][c];
        end
    end

    assign w_elem       = r_buf[r_idx];
    assign m_axis_tlast = (r_state == SEND) && (r_idx == LAST);
    assign overrun      = r_overrun;

`ifdef AXI_OUT_SAT_EN
    logic signed [CONV_W-1:0] w_ext;
    logic        [CONV_W-1:0] w_sat;
    assign w_ext        = CONV_W'(signed'(w_elem));
    assign w_sat        = sat_conv(w_ext, OUT_W);
    assign m_axis_tdata = w_sat[OUT_W-1:0];
`else
    assign m_axis_tdata = w_elem[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_axi_output_adapter.sv
// Directed + randomized bench for axi_output_adapter (N=4, ACC_W=32, OUT_W=16).
module tb_axi_output_adapter;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic                    results_valid = 1'b0;
    logic [3:0][3:0][31:0]   results = '0;
    logic                    m_axis_tvalid;
    logic [15:0]             m_axis_tdata;
    logic                    m_axis_tlast;
    logic                    m_axis_tready = 1'b0;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    int          checks = 0;
    int          errors = 0;
    int          mat [4][4];
    logic [15:0] exp_q [$];

    axi_output_adapter #(.N(4), .ACC_W(32), .OUT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .results_valid (results_valid),
        .results       (results),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] conv(input int v);
`ifdef AXI_OUT_SAT_EN
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_mat();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mat[r][c] = int'($urandom);
    endtask

    task automatic capture();
        @(negedge clk);
        exp_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                results[r][c] = mat[r][c];
                exp_q.push_back(conv(mat[r][c]));
            end
        enable        = 1'b1;
        results_valid = 1'b1;
    endtask

    // mode 0: ready high, 1: ready toggles 1010, 2: random ready
    task automatic run_stream(input int mode, input int pulse_at);
        int          k = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic        pulsed = 1'b0;
        logic [15:0] pd = '0;
        logic        pl = 1'b0;
        while (k < 16 && cyc < 400) begin
            @(negedge clk);
            results_valid = 1'b0;
            if (k == pulse_at && !pulsed) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        results[r][c] = $urandom;
                results_valid = 1'b1;
                pulsed        = 1'b1;
            end
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (cyc % 2 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            check("tvalid_send", 32'(m_axis_tvalid), 32'd1);
            check("busy_send", 32'(busy), 32'd1);
            if (stalled) begin
                check("hold_tdata", 32'(m_axis_tdata), 32'(pd));
                check("hold_tlast", 32'(m_axis_tlast), 32'(pl));
            end
            if (m_axis_tready) begin
                check("tdata", 32'(m_axis_tdata), 32'(exp_q[k]));
                check("tlast", 32'(m_axis_tlast), 32'(k == 15));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd      = m_axis_tdata;
                pl      = m_axis_tlast;
            end
            cyc++;
        end
        if (k < 16) check("stream_timeout", 32'(k), 32'd16);
        @(negedge clk);
        results_valid = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("tvalid_done", 32'(m_axis_tvalid), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("tvalid_idle", 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        rst = 1'b0;

        // 1: ramp matrix, ready held high
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mat[r][c] = r * 4 + c;
        capture();
        run_stream(0, -1);

        // 5: pulse with enable low is ignored
        @(negedge clk);
        rand_mat();
        results       = '1;
        enable        = 1'b0;
        results_valid = 1'b1;
        @(negedge clk);
        results_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ign_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("ign_overrun", 32'(overrun), 32'd0);
            @(negedge clk);
        end
        capture();
        run_stream(0, -1);

        // 3: conversion boundaries
        rand_mat();
        mat[0][0] = 40000;
        mat[0][1] = -40000;
        mat[0][2] = 32767;
        mat[0][3] = -32768;
        capture();
        run_stream(0, -1);

        // 2: ramp with toggling then random backpressure
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mat[r][c] = r * 4 + c;
        capture();
        run_stream(1, -1);
        rand_mat();
        capture();
        run_stream(2, -1);
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // 4: overlapping pulse at beat 5
        rand_mat();
        capture();
        run_stream(0, 5);
        check("overrun_set", 32'(overrun), 32'd1);
        rand_mat();
        capture();
        run_stream(2, -1);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // 6: reset mid-stream while stalled on beat 7
        rand_mat();
        capture();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            results_valid = 1'b0;
            m_axis_tready = 1'b1;
            check("pre_rst_tdata", 32'(m_axis_tdata), 32'(exp_q[i]));
        end
        @(negedge clk);
        m_axis_tready = 1'b0;
        check("beat7_tdata", 32'(m_axis_tdata), 32'(exp_q[7]));
        #2 rst = 1'b1;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_tdata", 32'(m_axis_tdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rand_mat();
        capture();
        run_stream(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
